multicycle_sequencer: RTL

Finite-state sequencer for the multicycle MIPS datapath. It walks each instruction through fetch, decode, execute, memory and write-back cycles, and drives the datapath's mux selects and write enables one phase at a time. It accepts a memory-ready handshake so the shared instruction/data memory may take wait states. It sits between the instruction register (opcode/funct) and the datapath control inputs, and exposes its state for debug.

---
 rtl/multicycle_pkg.sv | 54 +++++
 rtl/multicycle_sequencer_if.sv | 41 ++++
 rtl/multicycle_decode.sv | 35 +++
 rtl/multicycle_sequencer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// multicycle_pkg: shared types and constants for the multicycle MIPS sequencer.
//   state_e : FSM state codes (also exposed on the debug `state` port)
//   OP_*    : IR[31:26] opcodes recognised by DECODE
//   FN_*    : IR[5:0] funct codes recognised for R-type
//   ALUOP_* : ALUOp encodings driven to the ALU control
//   ctrl_t  : bundle of datapath controls produced each cycle
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_JUMP     = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10,
    S_BRANCH   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/multicycle_sequencer_if.sv
// multicycle_sequencer_if: IR fields, memory handshake and datapath controls
// between the sequencer and the multicycle datapath.
//   master : sequencer side (takes Opcode/Funct/mem_ready, drives controls,
//            state and illegal)
//   slave  : datapath side (the reverse)
interface multicycle_sequencer_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         Opcode;
  logic [5:0]         Funct;
  logic               mem_ready;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               MemToReg;
  logic               IRWrite;
  logic               RegDst;
  logic               RegWrite;
  logic               ALUSrcA;
  logic               PCWrite;
  logic               PCWriteCond;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ALUOp;
  logic [1:0]         PCSource;
  logic [STATE_W-1:0] state;
  logic               illegal;

  modport master (
    input  Opcode, Funct, mem_ready,
    output IorD, MemRead, MemWrite, MemToReg, IRWrite, RegDst, RegWrite,
           ALUSrcA, PCWrite, PCWriteCond, ALUSrcB, ALUOp, PCSource,
           state, illegal
  );

  modport slave (
    output Opcode, Funct, mem_ready,
    input  IorD, MemRead, MemWrite, MemToReg, IRWrite, RegDst, RegWrite,
           ALUSrcA, PCWrite, PCWriteCond, ALUSrcB, ALUOp, PCSource,
           state, illegal
  );
endinterface

// File: rtl/multicycle_decode.sv
// multicycle_decode: combinational instruction classifier used in DECODE.
//   opcode_i  : IR[31:26]
//   funct_i   : IR[5:0]
//   next_o    : state that follows DECODE
//   illegal_o : instruction not supported (next_o is then FETCH)
// Build option: MULTICYCLE_BEQ_EN routes BEQ to the BRANCH state; without it
// BEQ is reported illegal.
module multicycle_decode
  import multicycle_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output state_e     next_o,
  output logic       illegal_o
);

  always_comb begin
    next_o    = S_FETCH;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_LW, OP_SW: next_o = S_MEMADDR;
      OP_RTYPE: begin
        if (funct_i == FN_ADD || funct_i == FN_SUB) next_o = S_RTYPE_EX;
        else                                        illegal_o = 1'b1;
      end
      OP_J:    next_o = S_JUMP;
      OP_ADDI: next_o = S_ADDI_EX;
`ifdef MULTICYCLE_BEQ_EN
      OP_BEQ:  next_o = S_BRANCH;
`endif
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: control FSM for the multicycle MIPS datapath.
// Walks each instruction through fetch/decode/execute/memory/write-back and
// drives the datapath controls for the current phase. FETCH, MEMRD and MEMWR
// stall on mem_ready.
//   Clk   : system clock, rising edge
//   reset : asynchronous active-low; state -> FETCH, enables held at 0
//   bus   : multicycle_sequencer_if.master (IR fields, mem_ready, controls,
//           debug state, illegal pulse)
// Build option: MULTICYCLE_BEQ_EN enables the BRANCH state (BEQ support).
module multicycle_sequencer
  import multicycle_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic                   Clk,
  input  logic                   reset,
  multicycle_sequencer_if.master bus
);

  state_e state_q, state_d;
  // LW/SW split is latched in DECODE so MEMADDR never looks at the IR.
  logic   is_sw_q, is_sw_d;
  state_e dec_next;
  logic   dec_ill;
  ctrl_t  ctrl;
  logic   illegal;

  multicycle_decode u_dec (
    .opcode_i  (bus.Opcode),
    .funct_i   (bus.Funct),
    .next_o    (dec_next),
    .illegal_o (dec_ill)
  );

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      is_sw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_sw_q <= is_sw_d;
    end
  end

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    state_d = state_q;
    is_sw_d = is_sw_q;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = ALUOP_ADD;
        // IR and PC+4 only commit on the cycle the fetch completes.
        ctrl.ir_write  = bus.mem_ready;
        ctrl.pc_write  = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ctrl.alu_src_b = 2'b11;
        ctrl.alu_op    = ALUOP_ADD;
        state_d        = dec_next;
        illegal        = dec_ill;
        is_sw_d        = (bus.Opcode == OP_SW);
      end
      S_MEMADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ALUOP_ADD;
        state_d        = is_sw_q ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_RTYPE_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b00;
        ctrl.alu_op    = ALUOP_FUNCT;
        state_d        = S_RTYPE_WB;
      end
      S_RTYPE_WB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        state_d        = S_FETCH;
      end
      S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ALUOP_ADD;
        state_d        = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
        state_d        = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 2'b10;
        state_d        = S_FETCH;
      end
`ifdef MULTICYCLE_BEQ_EN
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = 2'b00;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 2'b01;
        state_d            = S_FETCH;
      end
`endif
      // Unused codes (and BRANCH when BEQ is disabled): all controls 0,
      // recover to FETCH. pc_write_cond therefore stays 0 without BEQ.
      default: state_d = S_FETCH;
    endcase

    // Reset is asynchronous; mask every write/read strobe combinationally so
    // nothing commits in the cycle reset falls. Selects keep FETCH values.
    if (!reset) begin
      ctrl.mem_read      = 1'b0;
      ctrl.mem_write     = 1'b0;
      ctrl.ir_write      = 1'b0;
      ctrl.pc_write      = 1'b0;
      ctrl.pc_write_cond = 1'b0;
      ctrl.reg_write     = 1'b0;
    end
  end

  assign bus.IorD        = ctrl.iord;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.MemToReg    = ctrl.mem_to_reg;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.state       = STATE_W'(state_q);
  assign bus.illegal     = illegal;

endmodule
